// File: rtl/lab3_keypad_scanner.sv
// 4x4 keypad row scanner with 2-flop column sync and press/release debounce.
// Key reaches new_key within 2 + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles; no backpressure, outputs held until release.
module lab3_keypad_scanner #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_drive,
    output logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic       new_key
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] S_ONE     = SW'(1);
    localparam logic [DW-1:0] D_ONE     = DW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_DB} state_t;

    state_t        state_q;
    logic [3:0]    sync1_q, col_s_q;
    logic [3:0]    row_q, cap_col_q, cap_row_q;
    logic [3:0]    cols_q, rows_q;
    logic          key_valid_q, new_key_q;
    logic [SW-1:0] dwell_q;
    logic [DW-1:0] db_q;

    logic [3:0]    row_rot_d;
    logic          col_onehot_d;
    logic          cap_bit_d;

    assign row_rot_d    = {row_q[2:0], row_q[3]};
    assign col_onehot_d = (col_s_q != 4'b0000) && ((col_s_q & (col_s_q - 4'd1)) == 4'b0000);
    assign cap_bit_d    = |(col_s_q & cap_col_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            sync1_q     <= 4'b0000;
            col_s_q     <= 4'b0000;
            row_q       <= 4'b0001;
            cap_col_q   <= 4'b0000;
            cap_row_q   <= 4'b0000;
            cols_q      <= 4'b0000;
            rows_q      <= 4'b0000;
            key_valid_q <= 1'b0;
            new_key_q   <= 1'b0;
            dwell_q     <= '0;
            db_q        <= '0;
        end else begin
            sync1_q   <= col_in;
            col_s_q   <= sync1_q;
            new_key_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    // Sampling only at the end of the dwell gives the sync chain time to settle on the new row.
                    if (dwell_q == SCAN_LAST) begin
                        dwell_q <= '0;
                        if (col_onehot_d) begin
                            cap_col_q <= col_s_q;
                            cap_row_q <= row_q;
                            db_q      <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            row_q <= row_rot_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + S_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q != cap_col_q) begin
                        row_q   <= row_rot_d;
                        dwell_q <= '0;
                        db_q    <= '0;
                        state_q <= SCAN;
                    end else if (db_q == DB_LAST) begin
                        cols_q      <= cap_col_q;
                        rows_q      <= cap_row_q;
                        key_valid_q <= 1'b1;
                        new_key_q   <= 1'b1;
                        db_q        <= '0;
                        state_q     <= HELD;
                    end else begin
                        db_q <= db_q + D_ONE;
                    end
                end
                HELD: begin
                    if (!cap_bit_d) begin
                        db_q    <= '0;
                        state_q <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    // A short dropout returns to HELD silently so one press never yields two strobes.
                    if (cap_bit_d) begin
                        db_q    <= '0;
                        state_q <= HELD;
                    end else if (db_q == DB_LAST) begin
                        cols_q      <= 4'b0000;
                        rows_q      <= 4'b0000;
                        key_valid_q <= 1'b0;
                        row_q       <= row_rot_d;
                        dwell_q     <= '0;
                        db_q        <= '0;
                        state_q     <= SCAN;
                    end else begin
                        db_q <= db_q + D_ONE;
                    end
                end
                default: begin
                    dwell_q <= '0;
                    db_q    <= '0;
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign row_drive = row_q;
    assign cols      = cols_q;
    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign new_key   = new_key_q;

endmodule
